// File: rtl/oled_fb_pkg.sv
// oled_fb_pkg: shared geometry, widths, FSM states and RGB332 helpers for the OLED fill frame buffer.
package oled_fb_pkg;
    localparam int C_X_BITS     = 7;
    localparam int C_Y_BITS     = 6;
    localparam int C_COLOR_BITS = 8;
    localparam int C_WIDTH      = 96;
    localparam int C_HEIGHT     = 64;
    localparam logic [C_COLOR_BITS-1:0] C_CLEAR_COLOR = 8'h00;

    typedef enum logic [1:0] {CLEAR, IDLE, FILL} state_t;

    function automatic logic [7:0] rgb332(input logic [2:0] r, input logic [2:0] g, input logic [1:0] b);
        return {r, g, b};
    endfunction

    function automatic logic [2:0] rgb332_r(input logic [7:0] c);
        return c[7:5];
    endfunction

    function automatic logic [2:0] rgb332_g(input logic [7:0] c);
        return c[4:2];
    endfunction

    function automatic logic [1:0] rgb332_b(input logic [7:0] c);
        return c[1:0];
    endfunction
endpackage

// File: rtl/oled_fb_ram.sv
// oled_fb_ram: simple dual-port RAM, one synchronous write and one synchronous read port, read-before-write.
module oled_fb_ram #(
    parameter int AW = 13,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/oled_fill_framebuffer.sv
// oled_fill_framebuffer: 96x64 RGB332 frame buffer feeding oled_video; clears itself after reset,
// then executes solid rectangle fills one pixel per clock.
module oled_fill_framebuffer import oled_fb_pkg::*; #(
    parameter int C_x_bits     = C_X_BITS,
    parameter int C_y_bits     = C_Y_BITS,
    parameter int C_color_bits = C_COLOR_BITS,
    parameter int C_width      = C_WIDTH,
    parameter int C_height     = C_HEIGHT,
    parameter logic [C_color_bits-1:0] C_clear_color = C_CLEAR_COLOR
) (
    input  logic                    clk,
    input  logic                    resn,
    input  logic [C_x_bits-1:0]     x,
    input  logic [C_y_bits-1:0]     y,
    output logic [C_color_bits-1:0] color,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [C_x_bits-1:0]     cmd_x0,
    input  logic [C_x_bits-1:0]     cmd_x1,
    input  logic [C_y_bits-1:0]     cmd_y0,
    input  logic [C_y_bits-1:0]     cmd_y1,
    input  logic [C_color_bits-1:0] cmd_color,
    output logic                    busy
);
    localparam logic [C_x_bits-1:0] x_max = C_x_bits'(C_width - 1);
    localparam logic [C_y_bits-1:0] y_max = C_y_bits'(C_height - 1);

    state_t                  state;
    logic [C_x_bits-1:0]     cur_x, fx0, fx1, x1c;
    logic [C_y_bits-1:0]     cur_y, fy1, y1c;
    logic [C_color_bits-1:0] fcol, ram_q;
    logic                    oob_q, degenerate, we;

    assign x1c        = (cmd_x1 > x_max) ? x_max : cmd_x1;
    assign y1c        = (cmd_y1 > y_max) ? y_max : cmd_y1;
    assign degenerate = (cmd_x0 > x1c) || (cmd_y0 > y1c);
    assign we         = resn && (state != IDLE);
    assign busy       = !cmd_ready;
    assign color      = oob_q ? C_clear_color : ram_q;

    // CLEAR is a full-screen fill: reset loads the rectangle registers with the screen and clear colour
    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            state     <= CLEAR;
            cur_x     <= '0;
            cur_y     <= '0;
            fx0       <= '0;
            fx1       <= x_max;
            fy1       <= y_max;
            fcol      <= C_clear_color;
            cmd_ready <= 1'b0;
        end else if (state == IDLE) begin
            if (!cmd_ready) begin
                cmd_ready <= 1'b1;
            end else if (cmd_valid) begin
                cmd_ready <= 1'b0;
                fx0       <= cmd_x0;
                fx1       <= x1c;
                fy1       <= y1c;
                fcol      <= cmd_color;
                cur_x     <= cmd_x0;
                cur_y     <= cmd_y0;
                if (!degenerate) state <= FILL;
            end
        end else if (cur_x != fx1) begin
            cur_x <= cur_x + 1'b1;
        end else if (cur_y != fy1) begin
            cur_x <= fx0;
            cur_y <= cur_y + 1'b1;
        end else begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resn) begin
        if (!resn) oob_q <= 1'b1;
        else       oob_q <= (x > x_max) || (y > y_max);
    end

    oled_fb_ram #(.AW(C_x_bits + C_y_bits), .DW(C_color_bits)) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr ({cur_y, cur_x}),
        .wdata (fcol),
        .raddr ({y, x}),
        .rdata (ram_q)
    );
endmodule

// File: tb/tb_oled_fill_framebuffer.sv
// tb_oled_fill_framebuffer: directed bench for the OLED fill frame buffer.
module tb_oled_fill_framebuffer;
    logic       clk = 1'b0;
    logic       resn = 1'b0;
    logic [6:0] x = 7'd10, cmd_x0 = '0, cmd_x1 = '0;
    logic [5:0] y = 6'd10, cmd_y0 = '0, cmd_y1 = '0;
    logic [7:0] cmd_color = '0;
    logic       cmd_valid = 1'b0;
    logic [7:0] color;
    logic       cmd_ready, busy;
    int         n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    oled_fill_framebuffer dut (
        .clk       (clk),
        .resn      (resn),
        .x         (x),
        .y         (y),
        .color     (color),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_x0    (cmd_x0),
        .cmd_x1    (cmd_x1),
        .cmd_y0    (cmd_y0),
        .cmd_y1    (cmd_y1),
        .cmd_color (cmd_color),
        .busy      (busy)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic send(input int x0, input int y0, input int x1, input int y1, input logic [7:0] c);
        cmd_x0    = 7'(x0);
        cmd_y0    = 6'(y0);
        cmd_x1    = 7'(x1);
        cmd_y1    = 6'(y1);
        cmd_color = c;
        cmd_valid = 1'b1;
        for (int i = 0; i < 8000 && !cmd_ready; i++) @(negedge clk);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!cmd_ready && n < 10000);
    endtask

    task automatic rd(input int px, input int py, output logic [7:0] c);
        x = 7'(px);
        y = 6'(py);
        @(posedge clk);
        @(negedge clk);
        c = color;
    endtask

    task automatic scan(input logic [7:0] exp, output int bad);
        logic [7:0] c;
        bad = 0;
        for (int py = 0; py < 64; py++)
            for (int px = 0; px < 96; px++) begin
                rd(px, py, c);
                if (c != exp) bad++;
            end
    endtask

    initial begin
        logic [7:0] c;
        int n, bad;
        repeat (3) @(negedge clk);
        check("rst_ready", cmd_ready, 0);
        check("rst_busy", busy, 1);
        check("rst_color", color, 8'h00);
        resn = 1'b1;
        n = 0;
        bad = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (n > 1000 && color != 8'h00) bad++;
        end while (!cmd_ready && n < 10000);
        check("clear_len", n, 6144);
        check("clear_color", bad, 0);
        rd(95, 63, c);
        check("clear_corner", c, 8'h00);

        send(0, 0, 95, 63, 8'hE0);
        wait_ready(n);
        check("full_len", n, 6144);
        scan(8'hE0, bad);
        check("full_scan", bad, 0);

        send(90, 60, 127, 63, 8'h1C);
        wait_ready(n);
        check("clamp_len", n, 24);
        rd(95, 63, c); check("clamp_95_63", c, 8'h1C);
        rd(90, 60, c); check("clamp_90_60", c, 8'h1C);
        rd(89, 60, c); check("clamp_89_60", c, 8'hE0);
        rd(90, 59, c); check("clamp_90_59", c, 8'hE0);
        rd(100, 60, c); check("oob_100_60", c, 8'h00);
        rd(127, 63, c); check("oob_127_63", c, 8'h00);

        send(20, 5, 10, 5, 8'h55);
        @(negedge clk);
        check("degen_low", cmd_ready, 0);
        @(negedge clk);
        check("degen_back", cmd_ready, 1);
        rd(15, 5, c); check("degen_15_5", c, 8'hE0);
        rd(20, 5, c); check("degen_20_5", c, 8'hE0);
        rd(10, 5, c); check("degen_10_5", c, 8'hE0);

        x = 7'd5;
        y = 6'd5;
        @(negedge clk);
        send(5, 5, 5, 5, 8'h03);
        @(posedge clk);
        @(negedge clk);
        check("rbw_old", color, 8'hE0);
        check("rbw_ready", cmd_ready, 1);
        @(posedge clk);
        @(negedge clk);
        check("rbw_new", color, 8'h03);

        send(0, 0, 39, 39, 8'hAA);
        repeat (800) @(negedge clk);
        check("mid_busy", busy, 1);
        rd(0, 0, c);
        check("mid_written", c, 8'hAA);
        resn = 1'b0;
        @(negedge clk);
        check("abort_ready", cmd_ready, 0);
        resn = 1'b1;
        wait_ready(n);
        check("reclear_len", n, 6144);
        scan(8'h00, bad);
        check("reclear_scan", bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
